dm_arbiter: RTL and testbench

Round-robin arbiter that shares the single data memory `dm` among the `cores` CPU cores of the multi-core `cpu`. Each core's load/store port is a request/acknowledge channel. The arbiter serializes those requests onto the one memory port as a two-stage pipeline: issue, then response. With more than one core requesting, it sustains one memory access per cycle.

---
 rtl/dm_arb_pkg.sv | 19 +
 rtl/dm_arbiter_rr_pick.sv | 30 +++
 rtl/dm_arbiter.sv | 152 +++++++++++++++
 tb/tb_dm_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared encodings for the dm_arbiter data-memory arbiter
// (state names, owner-index width helper, "no owner" sentinel for the bus lock).
package dm_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_e;

  // Lock owner register is wide enough for index 0..7 plus one out-of-range value.
  localparam int                LOCK_W   = 4;
  localparam logic [LOCK_W-1:0] NO_OWNER = 4'd8;

  function automatic int owner_w(input int cores);
    return (cores > 1) ? $clog2(cores) : 1;
  endfunction

endpackage

// File: rtl/dm_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search; returns the first eligible
// index at or after start (wrapping modulo N).
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] index
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  // rot[k] is the eligibility of core (start + k) mod N
  assign dbl = {elig, elig} >> start;
  assign rot = dbl[N-1:0];

  always_comb begin
    found = |rot;
    index = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        index = IW'((int'(start) + k) % N);
      end
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin sharing of one data-memory port among CORES cores
// through an issue/response pipeline. Define DM_ARB_LOCK_EN for bus-lock support.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int CORES  = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [CORES-1:0]        req,
  input  logic [CORES-1:0]        we,
  input  logic [CORES-1:0]        lock,
  input  logic [CORES*ADDR_W-1:0] addr,
  input  logic [CORES*DATA_W-1:0] wdata,
  output logic [CORES-1:0]        ack,
  output logic [DATA_W-1:0]       rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    busy
);

  localparam int OW = owner_w(CORES);

  logic              iss_valid_q, iss_valid_d;
  logic [OW-1:0]     iss_owner_q, iss_owner_d;
  logic              iss_we_q, iss_we_d;
  logic [ADDR_W-1:0] iss_addr_q, iss_addr_d;
  logic [DATA_W-1:0] iss_wdata_q, iss_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [OW-1:0]     rsp_owner_q, rsp_owner_d;
  logic [OW-1:0]     last_q, last_d;

  logic [CORES-1:0]  elig, lock_mask, grant_oh;
  logic [OW-1:0]     start_ptr, grant_idx;
  logic              grant_found;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // A core already in flight is excluded so its held req is not granted twice.
  for (genvar gi = 0; gi < CORES; gi++) begin : g_elig
    assign elig[gi] = req[gi] & lock_mask[gi]
                    & ~(iss_valid_q & (iss_owner_q == OW'(gi)))
                    & ~(rsp_valid_q & (rsp_owner_q == OW'(gi)));
  end

  assign start_ptr = (last_q == OW'(CORES - 1)) ? '0 : last_q + 1'b1;

  rr_pick #(.N(CORES), .IW(OW)) u_rr_pick (
    .elig  (elig),
    .start (start_ptr),
    .found (grant_found),
    .index (grant_idx)
  );

  assign grant_oh = grant_found ? (CORES'(1) << grant_idx) : '0;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < CORES; i++) begin
      if (grant_oh[i]) begin
        sel_we    = we[i];
        sel_addr  = addr[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    iss_valid_d = grant_found;
    iss_owner_d = grant_found ? grant_idx : '0;
    iss_we_d    = sel_we;
    iss_addr_d  = sel_addr;
    iss_wdata_d = sel_wdata;
    rsp_valid_d = iss_valid_q;
    rsp_owner_d = iss_owner_q;
    last_d      = grant_found ? grant_idx : last_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iss_valid_q <= 1'b0;
      iss_owner_q <= '0;
      iss_we_q    <= 1'b0;
      iss_addr_q  <= '0;
      iss_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= '0;
      last_q      <= OW'(CORES - 1);
    end else begin
      iss_valid_q <= iss_valid_d;
      iss_owner_q <= iss_owner_d;
      iss_we_q    <= iss_we_d;
      iss_addr_q  <= iss_addr_d;
      iss_wdata_q <= iss_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_owner_q <= rsp_owner_d;
      last_q      <= last_d;
    end
  end

`ifdef DM_ARB_LOCK_EN
  logic [LOCK_W-1:0] lock_owner_q, lock_owner_d;
  logic [CORES-1:0]  lock_oh;
  logic              lock_held, sel_lock;

  assign lock_held = (lock_owner_q != NO_OWNER);
  assign lock_oh   = lock_held ? (CORES'(1) << lock_owner_q) : '0;
  assign lock_mask = lock_held ? lock_oh : '1;
  assign sel_lock  = |(lock & grant_oh);

  always_comb begin
    lock_owner_d = lock_owner_q;
    if (grant_found && sel_lock) begin
      lock_owner_d = LOCK_W'(grant_idx);
    end else if (grant_found && |(grant_oh & lock_oh)) begin
      lock_owner_d = NO_OWNER;
    end else if (lock_held && !(|(req & lock_oh)) && !(|(lock & lock_oh))) begin
      lock_owner_d = NO_OWNER;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_owner_q <= NO_OWNER;
    end else begin
      lock_owner_q <= lock_owner_d;
    end
  end
`else
  logic unused_lock;
  assign lock_mask   = '1;
  assign unused_lock = ^lock;
`endif

  assign mem_en    = iss_valid_q;
  assign mem_we    = iss_we_q;
  assign mem_addr  = iss_addr_q;
  assign mem_wdata = iss_wdata_q;
  assign ack       = rsp_valid_q ? (CORES'(1) << rsp_owner_q) : '0;
  // Gated so that every output reads 0 while the pipeline is empty or in reset.
  assign rdata     = rsp_valid_q ? mem_rdata : '0;
  assign busy      = iss_valid_q | rsp_valid_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: scoreboard bench for dm_arbiter (CORES=4 and CORES=1 instances)
// with synchronous memory models; lock scenario runs only with DM_ARB_LOCK_EN.
module tb_dm_arbiter;

  typedef struct {
    bit          chk;
    logic [31:0] data;
  } sb_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [3:0]   req_r, we_r, lock_r;
  logic [39:0]  addr_r;
  logic [127:0] wdata_r;
  logic [3:0]   ack;
  logic [31:0]  rdata, mem_wdata, mem_rdata;
  logic         mem_en, mem_we, busy;
  logic [9:0]   mem_addr;
  logic [31:0]  mem [0:1023];

  logic         s_req, s_we, s_ack, s_mem_en, s_mem_we, s_busy;
  logic [9:0]   s_addr, s_mem_addr;
  logic [31:0]  s_wdata, s_rdata, s_mem_wdata, s_mem_rdata;
  logic [31:0]  mem1 [0:1023];

  sb_t sb_q [4][$];
  sb_t sb1_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dm_arbiter #(.CORES(4), .ADDR_W(10), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .req(req_r), .we(we_r), .lock(lock_r),
    .addr(addr_r), .wdata(wdata_r), .ack(ack), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  dm_arbiter #(.CORES(1), .ADDR_W(10), .DATA_W(32)) dut1 (
    .clk(clk), .reset_n(reset_n), .req(s_req), .we(s_we), .lock(1'b0),
    .addr(s_addr), .wdata(s_wdata), .ack(s_ack), .rdata(s_rdata),
    .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata), .busy(s_busy)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
    if (s_mem_en) begin
      if (s_mem_we) mem1[s_mem_addr] <= s_mem_wdata;
      s_mem_rdata <= mem1[s_mem_addr];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitors: pop the acking core's expectation and compare load data.
  always @(negedge clk) begin
    sb_t e;
    if (reset_n) begin
      check("ack_onehot", 64'($onehot0(ack)), 64'd1);
      for (int c = 0; c < 4; c++) begin
        if (ack[c]) begin
          if (sb_q[c].size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_ack core=%0d actual=ack required=none", c);
          end else begin
            e = sb_q[c].pop_front();
            if (e.chk) check($sformatf("rdata_core%0d", c), rdata, e.data);
            else n_cmp++;
            $display("ack core=%0d rdata=%0h", c, rdata);
          end
        end
      end
      if (s_ack) begin
        if (sb1_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_ack1 actual=ack required=none");
        end else begin
          e = sb1_q.pop_front();
          if (e.chk) check("rdata_single", s_rdata, e.data);
          else n_cmp++;
          $display("ack single rdata=%0h", s_rdata);
        end
      end
    end
  end

  task automatic access(input int c, input bit w, input logic [9:0] a, input logic [31:0] d,
                        input bit lk, input logic [31:0] exp, output logic [31:0] got, output int lat);
    sb_t e;
    int  t0;
    bit  seen;
    e.chk = !w; e.data = exp;
    sb_q[c].push_back(e);
    req_r[c] = 1'b1; we_r[c] = w; lock_r[c] = lk;
    addr_r[c*10 +: 10] = a; wdata_r[c*32 +: 32] = d;
    t0 = cyc; seen = 1'b0; got = '0; lat = -1;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (ack[c]) begin seen = 1'b1; got = rdata; lat = cyc - t0; end
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL ack_timeout core=%0d actual=none required=ack", c);
    end
    @(posedge clk); #1;
    req_r[c] = 1'b0; lock_r[c] = 1'b0;
  endtask

  task automatic access1(input bit w, input logic [9:0] a, input logic [31:0] d,
                         input logic [31:0] exp, output int lat);
    sb_t e;
    int  t0;
    bit  seen;
    e.chk = !w; e.data = exp;
    sb1_q.push_back(e);
    s_req = 1'b1; s_we = w; s_addr = a; s_wdata = d;
    t0 = cyc; seen = 1'b0; lat = -1;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (s_ack) begin seen = 1'b1; lat = cyc - t0; end
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL ack_timeout_single actual=none required=ack");
    end
    @(posedge clk); #1;
    s_req = 1'b0;
  endtask

  task automatic swap_pair(input int c);
    logic [31:0] v1, v2, g;
    int l;
    access(c, 1'b0, 10'(c), 32'd0, 1'b0, 32'(c + 1), v1, l);
    access(c, 1'b0, 10'(7 - c), 32'd0, 1'b0, 32'(8 - c), v2, l);
    access(c, 1'b1, 10'(c), v2, 1'b0, 32'd0, g, l);
    access(c, 1'b1, 10'(7 - c), v1, 1'b0, 32'd0, g, l);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_r = '0; lock_r = '0; s_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] g0, g1, g2, g3;
    int l0, l1, l2, l3;
    req_r = '0; we_r = '0; lock_r = '0; addr_r = '0; wdata_r = '0;
    s_req = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0;

    // Reset state
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rdata", rdata, 0);
    check("rst_busy", busy, 0);
    check("rst1_ack", s_ack, 0);
    check("rst1_mem_en", s_mem_en, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Single core: store 8 to addr 0, load it back
    access1(1'b1, 10'd0, 32'd8, 32'd0, l0);
    check("single_store_lat", l0, 2);
    access1(1'b0, 10'd0, 32'd0, 32'd8, l1);
    check("single_load_lat", l1, 2);

    // Preload words 16..23 = A0..A7 through core 0
    for (int k = 0; k < 8; k++) access(0, 1'b1, 10'(16 + k), 32'hA0 + k, 1'b0, 32'd0, g0, l0);

    // Two cores simultaneous from the reset pointer
    do_reset();
    fork
      access(0, 1'b0, 10'd16, 32'd0, 1'b0, 32'hA0, g0, l0);
      access(1, 1'b0, 10'd17, 32'd0, 1'b0, 32'hA1, g1, l1);
      begin
        @(negedge clk); check("two_N_en", mem_en, 0);
        @(negedge clk); check("two_N1_en", mem_en, 1); check("two_N1_addr", mem_addr, 16);
        @(negedge clk); check("two_N2_addr", mem_addr, 17); check("two_N2_ack", ack, 4'b0001);
        @(negedge clk); check("two_N3_ack", ack, 4'b0010);
      end
    join
    check("two_lat0", l0, 2);
    check("two_lat1", l1, 3);

    // Reset mid-flight
    do_reset();
    we_r = '0; addr_r[9:0] = 10'd16; addr_r[19:10] = 10'd17; req_r = 4'b0011;
    @(negedge clk);
    @(negedge clk);
    check("rstmid_en_before", mem_en, 1);
    reset_n = 1'b0;
    #1;
    check("rstmid_en", mem_en, 0);
    check("rstmid_ack", ack, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_addr", mem_addr, 0);
    check("rstmid_rdata", rdata, 0);
    req_r = '0;
    repeat (2) begin @(negedge clk); check("rstmid_noack", ack, 0); end
    @(posedge clk); #1 reset_n = 1'b1;

    // Four cores continuously requesting, 8 accesses
    fork
      begin access(0, 1'b0, 10'd16, 0, 1'b0, 32'hA0, g0, l0); access(0, 1'b0, 10'd20, 0, 1'b0, 32'hA4, g0, l0); end
      begin access(1, 1'b0, 10'd17, 0, 1'b0, 32'hA1, g1, l1); access(1, 1'b0, 10'd21, 0, 1'b0, 32'hA5, g1, l1); end
      begin access(2, 1'b0, 10'd18, 0, 1'b0, 32'hA2, g2, l2); access(2, 1'b0, 10'd22, 0, 1'b0, 32'hA6, g2, l2); end
      begin access(3, 1'b0, 10'd19, 0, 1'b0, 32'hA3, g3, l3); access(3, 1'b0, 10'd23, 0, 1'b0, 32'hA7, g3, l3); end
      begin
        @(negedge clk); check("four_N_en", mem_en, 0);
        for (int k = 1; k <= 8; k++) begin
          @(negedge clk);
          check($sformatf("four_en_%0d", k), mem_en, 1);
          check($sformatf("four_addr_%0d", k), mem_addr, 64'(15 + k));
        end
      end
    join

    // Reversal: words 0..7 = 1..8, each core swaps its pair
    for (int k = 0; k < 8; k++) access(0, 1'b1, 10'(k), 32'(k + 1), 1'b0, 32'd0, g0, l0);
    fork
      swap_pair(0);
      swap_pair(1);
      swap_pair(2);
      swap_pair(3);
    join
    for (int k = 0; k < 8; k++) access(0, 1'b0, 10'(k), 32'd0, 1'b0, 32'(8 - k), g0, l0);

`ifdef DM_ARB_LOCK_EN
    // Lock: core 2 holds the bus across its load/store pair
    do_reset();
    fork
      begin
        access(2, 1'b0, 10'd3, 32'd0, 1'b1, 32'd5, g2, l2);
        access(2, 1'b1, 10'd3, 32'h55, 1'b0, 32'd0, g2, l2);
      end
      begin
        @(posedge clk); #1;
        fork
          access(0, 1'b0, 10'd16, 0, 1'b0, 32'hA0, g0, l0);
          access(1, 1'b0, 10'd17, 0, 1'b0, 32'hA1, g1, l1);
          access(3, 1'b0, 10'd19, 0, 1'b0, 32'hA3, g3, l3);
        join
      end
      begin
        @(negedge clk); check("lock_N_en", mem_en, 0);
        @(negedge clk); check("lock_N1_en", mem_en, 1); check("lock_N1_addr", mem_addr, 3);
        @(negedge clk); check("lock_N2_en", mem_en, 0);
        @(negedge clk); check("lock_N3_en", mem_en, 0);
        @(negedge clk); check("lock_N4_we", mem_we, 1); check("lock_N4_addr", mem_addr, 3);
        @(negedge clk); check("lock_N5_en", mem_en, 1); check("lock_N5_addr", mem_addr, 19);
      end
    join
`endif

    repeat (3) @(negedge clk);
    for (int c = 0; c < 4; c++) check($sformatf("sb_empty_%0d", c), sb_q[c].size(), 0);
    check("sb1_empty", sb1_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
